// File: rtl/bank_write_sequencer.sv
// bank_write_sequencer: one-at-a-time bank write with read-hazard stall and ack wait.
// Optional ack timeout enabled by defining BANK_WR_TIMEOUT_EN.
module bank_write_sequencer #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [1:0]        wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [3:0]        rd_active,
    output logic [3:0]        bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [DATA_W-1:0] bank_wdata,
    input  logic [3:0]        bank_ack,
    output logic              wr_done,
    output logic              wr_err
);
    typedef enum logic [1:0] {IDLE, ARB, WRITE, RESP} state_t;
    state_t            state_q, state_d;
    logic [1:0]        bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d, bank_addr_q, bank_addr_d;
    logic [DATA_W-1:0] data_q, data_d, bank_wdata_q, bank_wdata_d;
    logic              accept, hit_ack;
    assign wr_ready   = (state_q == IDLE) || (state_q == RESP);
    assign accept     = wr_valid && wr_ready;
    assign hit_ack    = bank_ack[bank_q];
    assign bank_we    = (state_q == WRITE) ? (4'b0001 << bank_q) : 4'b0000;
    assign bank_addr  = bank_addr_q;
    assign bank_wdata = bank_wdata_q;
`ifdef BANK_WR_TIMEOUT_EN
    localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    assign wr_done = (state_q == RESP) && !err_q;
    assign wr_err  = (state_q == RESP) && err_q;
`else
    logic unused_tmo;
    assign unused_tmo = ^8'(TIMEOUT_CYCLES);
    assign wr_done    = state_q == RESP;
    assign wr_err     = 1'b0;
`endif
    always_comb begin
        state_d      = state_q;
        bank_d       = accept ? wr_bank : bank_q;
        addr_d       = accept ? wr_addr : addr_q;
        data_d       = accept ? wr_data : data_q;
        bank_addr_d  = bank_addr_q;
        bank_wdata_d = bank_wdata_q;
`ifdef BANK_WR_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: state_d = accept ? ARB : IDLE;
            ARB: if (!rd_active[bank_q]) begin
                state_d      = WRITE;
                bank_addr_d  = addr_q;
                bank_wdata_d = data_q;
`ifdef BANK_WR_TIMEOUT_EN
                cnt_d        = 8'd0;
`endif
            end
            WRITE: if (hit_ack) begin
                state_d = RESP;
`ifdef BANK_WR_TIMEOUT_EN
                err_d   = 1'b0;
            end else if (cnt_q + 8'd1 == TMO) begin
                state_d = RESP;
                err_d   = 1'b1;
            end else begin
                cnt_d   = cnt_q + 8'd1;
`endif
            end
            RESP: state_d = accept ? ARB : IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bank_q       <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            bank_addr_q  <= '0;
            bank_wdata_q <= '0;
`ifdef BANK_WR_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            bank_addr_q  <= bank_addr_d;
            bank_wdata_q <= bank_wdata_d;
`ifdef BANK_WR_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end
endmodule
